mem_fill_responder: RTL and testbench

Backing-memory responder that serves the cache's miss traffic. It accepts line-fill read requests and single-word write-through requests over a valid/ready request channel. Read data returns as a fixed-length burst of beats over a valid/ready response channel after a programmable access latency. It sits below the cache, replacing the flat preloaded array as the model of main memory.

---
 rtl/mem_fill_pkg.sv | 17 +
 rtl/mem_fill_ram.sv | 31 +++
 rtl/mem_fill_responder.sv | 140 ++++++++++++++
 tb/tb_mem_fill_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill responder: FSM states, beat index and latency counter.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } state_t;

    localparam int unsigned BEAT_COUNT_DEFAULT = 4;
    typedef logic [$clog2(BEAT_COUNT_DEFAULT)-1:0] beat_idx_t;

    localparam int unsigned LAT_CNT_W = 8;
    typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/mem_fill_ram.sv
// Single-port synchronous storage with one write port and one registered read port.
// Contents are deliberately not reset so they survive a responder reset.
module mem_fill_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read register only updates on an explicit read so a stalled beat holds its value.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            ram[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= ram[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_fill_responder.sv
// Main-memory responder: line-fill read bursts and write-through writes after a fixed latency.
// Optional macro MEM_FILL_CRITICAL_WORD_FIRST_EN starts each burst at the requested word.
module mem_fill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int BEAT_COUNT = 4,
    parameter int MEM_DEPTH  = 2048,
    parameter int LATENCY    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_last_o,
    output logic                  wr_done_o
);

    import mem_fill_pkg::*;

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int BEAT_W = $clog2(BEAT_COUNT);

    state_t              state_q, state_d;
    lat_cnt_t            cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BEAT_W-1:0]   start;
    logic [BEAT_W-1:0]   rd_off;
    logic                ram_we;
    logic                ram_re;
    logic [IDX_W-1:0]    ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                unused_addr;

    // Upper address bits alias onto the same storage.
    assign unused_addr = ^req_addr_i;

`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
    assign start = idx_q[BEAT_W-1:0];
`else
    assign start = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
        end
    end

    // The next beat is prefetched one cycle ahead: on the last WAIT cycle and on each transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        we_d    = we_q;
        idx_d   = idx_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    idx_d   = req_addr_i[IDX_W-1:0];
                    cnt_d   = lat_cnt_t'(LATENCY - 1);
                    beat_d  = '0;
                    ram_we  = req_we_i;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        state_d = WACK;
                    end else begin
                        ram_re  = 1'b1;
                        state_d = BURST;
                    end
                end else begin
                    cnt_d = cnt_q - lat_cnt_t'(1);
                end
            end
            BURST: begin
                if (rsp_ready_i) begin
                    if (beat_q == BEAT_W'(BEAT_COUNT - 1)) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        ram_re = 1'b1;
                    end
                end
            end
            WACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_off   = start + beat_d;
        ram_addr = (state_q == IDLE) ? req_addr_i[IDX_W-1:0]
                                     : {idx_q[IDX_W-1:BEAT_W], rd_off};
    end

    mem_fill_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (req_wdata_i),
        .rdata_o (ram_rdata)
    );

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == BURST);
    assign rsp_last_o  = rsp_valid_o && (beat_q == BEAT_W'(BEAT_COUNT - 1));
    assign wr_done_o   = (state_q == WACK);
    assign rsp_data_o  = rsp_valid_o ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder against an array-based memory model.
// Honours MEM_FILL_CRITICAL_WORD_FIRST_EN when computing expected beat order.
module tb_mem_fill_responder;

    localparam int AW    = 32;
    localparam int DW    = 8;
    localparam int BC    = 4;
    localparam int DEPTH = 2048;
    localparam int LAT   = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_last_o;
    logic          wr_done_o;

    logic [7:0] mem [DEPTH];
    int vectors = 0;
    int miscompares = 0;

    mem_fill_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_last_o  (rsp_last_o),
        .wr_done_o   (wr_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected beat k of a line read, straight from the addressing rules.
    function automatic logic [7:0] expBeat(input logic [AW-1:0] addr, input int k);
        int idx;
        int base;
        int start;
        idx  = int'(addr % AW'(DEPTH));
        base = idx - (idx % BC);
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
        start = idx % BC;
`else
        start = 0;
`endif
        return mem[base + ((start + k) % BC)];
    endfunction

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input bit hold, input logic [AW-1:0] holdAddr);
        int waitCyc = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        while (!req_ready_o && waitCyc < 100) begin
            @(negedge clk_i);
            waitCyc++;
        end
        if (!req_ready_o) begin
            checkOutput("acceptTimeout", 32'(req_ready_o), 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        if (we) mem[int'(addr % AW'(DEPTH))] = wdata;
        #1;
        if (hold) begin
            req_we_i   = 1'b0;
            req_addr_i = holdAddr;
        end else begin
            req_valid_i = 1'b0;
        end
    endtask

    task automatic collectWrite(input bit doCheck);
        for (int cyc = 0; cyc <= LAT; cyc++) begin
            @(negedge clk_i);
            if (doCheck) begin
                checkOutput("wrDone", 32'(wr_done_o), 32'(cyc == LAT));
                checkOutput("wrBusy", 32'(req_ready_o), 32'd0);
                checkOutput("wrNoBeat", 32'(rsp_valid_o), 32'd0);
            end
        end
        @(negedge clk_i);
        if (doCheck) begin
            checkOutput("wrDonePulse", 32'(wr_done_o), 32'd0);
            checkOutput("wrReadyBack", 32'(req_ready_o), 32'd1);
        end
    endtask

    // mode 0: always ready, 1: ready on alternate cycles, 2: random ready
    task automatic collectRead(input logic [AW-1:0] addr, input int mode);
        int k = 0;
        int cyc = 0;
        bit seen = 0;
        bit prevStall = 0;
        logic [7:0] prevData = '0;
        logic prevLast = 1'b0;
        logic rdy;
        while (k < BC && cyc < 200) begin
            @(negedge clk_i);
            checkOutput("rdBusy", 32'(req_ready_o), 32'd0);
            if (rsp_valid_o && !seen) begin
                seen = 1;
                checkOutput("firstBeatLat", 32'(cyc), 32'(LAT));
            end
            if (seen && !rsp_valid_o) checkOutput("validDrop", 32'(rsp_valid_o), 32'd1);
            if (!rsp_valid_o) checkOutput("lastIdle", 32'(rsp_last_o), 32'd0);
            if (prevStall) begin
                checkOutput("stallData", 32'(rsp_data_o), 32'(prevData));
                checkOutput("stallLast", 32'(rsp_last_o), 32'(prevLast));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 2) == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rsp_ready_i = rdy;
            if (rsp_valid_o && rdy) begin
                checkOutput($sformatf("beat%0d@%0h", k, addr), 32'(rsp_data_o), 32'(expBeat(addr, k)));
                checkOutput("lastFlag", 32'(rsp_last_o), 32'(k == BC - 1));
                k++;
            end
            prevStall = rsp_valid_o && !rdy;
            prevData  = rsp_data_o;
            prevLast  = rsp_last_o;
            cyc++;
        end
        if (k < BC) begin
            checkOutput("burstTimeout", 32'(k), 32'(BC));
        end else begin
            @(posedge clk_i);
            #1;
            checkOutput("readyAfterBurst", 32'(req_ready_o), 32'd1);
            checkOutput("validAfterBurst", 32'(rsp_valid_o), 32'd0);
        end
    endtask

    initial begin
        int k;
        int guard;
        logic we;
        logic [AW-1:0] addr;

        // Reset values
        #2;
        checkOutput("rstReady", 32'(req_ready_o), 32'd1);
        checkOutput("rstValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rstData", 32'(rsp_data_o), 32'd0);
        checkOutput("rstLast", 32'(rsp_last_o), 32'd0);
        checkOutput("rstWrDone", 32'(wr_done_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] preloading memory through the write path");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, AW'(i), i[7:0], 1'b0, '0);
            collectWrite(1'b0);
        end

        $display("[TB] line read at 0x105");
        applyStimulus(1'b0, 32'h105, '0, 1'b0, '0);
        collectRead(32'h105, 0);

        $display("[TB] write 0xA5 to 0x010 then read it back");
        applyStimulus(1'b1, 32'h010, 8'hA5, 1'b0, '0);
        collectWrite(1'b1);
        applyStimulus(1'b0, 32'h010, '0, 1'b0, '0);
        collectRead(32'h010, 0);

        $display("[TB] read 0x000 with alternating backpressure");
        applyStimulus(1'b0, 32'h000, '0, 1'b0, '0);
        collectRead(32'h000, 1);

        $display("[TB] aliased read 0x800 with a held follow-on request");
        applyStimulus(1'b0, 32'h800, '0, 1'b1, 32'h104);
        collectRead(32'h800, 0);
        applyStimulus(1'b0, 32'h104, '0, 1'b0, '0);
        collectRead(32'h104, 0);

        $display("[TB] reset during beat 2");
        applyStimulus(1'b0, 32'h000, '0, 1'b0, '0);
        rsp_ready_i = 1'b1;
        k = 0;
        guard = 0;
        while (guard < 50) begin
            @(negedge clk_i);
            guard++;
            if (rsp_valid_o) begin
                if (k == 2) break;
                k++;
            end
        end
        checkOutput("reachBeat2", 32'(k), 32'd2);
        rst_ni = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("midRstLast", 32'(rsp_last_o), 32'd0);
        checkOutput("midRstData", 32'(rsp_data_o), 32'd0);
        checkOutput("midRstReady", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("postRstReady", 32'(req_ready_o), 32'd1);
        checkOutput("postRstValid", 32'(rsp_valid_o), 32'd0);
        applyStimulus(1'b0, 32'h104, '0, 1'b0, '0);
        collectRead(32'h104, 0);
        applyStimulus(1'b0, 32'h012, '0, 1'b0, '0);
        collectRead(32'h012, 2);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 2) == 0);
            addr = $urandom;
            if (we) begin
                applyStimulus(1'b1, addr, 8'($urandom), 1'b0, '0);
                collectWrite(1'b1);
            end else begin
                applyStimulus(1'b0, addr, '0, 1'b0, '0);
                collectRead(addr, int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
